// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Request/response handshake bundle between issue logic and the shift sequencer.
interface shift_seq_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, busy
  );
endinterface

// File: rtl/shift_stage.sv
// One conditional power-of-two shift stage: shifts acc by 2**step when enabled.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 3
) (
  input  logic [WIDTH-1:0]  acc,
  input  op_e               op,
  input  logic [STEP_W-1:0] step,
  input  logic              enable,
  output logic [WIDTH-1:0]  result
);

  logic [31:0] dist_s;

  // Select the shifted or unchanged operand for this stage
  always_comb begin
    dist_s = 32'd1 << step;
    result = acc;
    if (enable) begin
      case (op)
        OP_SLL:  result = acc << dist_s;
        OP_SRL:  result = acc >> dist_s;
        OP_SRA:  result = $signed(acc) >>> dist_s;
        default: result = acc;
      endcase
    end else begin
      result = acc;
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer: one power-of-two stage per cycle, LSB of
// the shift amount first, so every nonzero shift takes exactly SHAMT_W cycles.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  shift_seq_if.slave bus
);

  localparam int STEP_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SHAMT_W - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  state_e             state_r;
  logic [STEP_W-1:0]  step_r;
  logic [WIDTH-1:0]   acc_r;
  logic [SHAMT_W-1:0] shamt_r;
  op_e                op_r;
  logic               rsp_valid_r;
  logic [WIDTH-1:0]   rsp_result_r;

  logic [WIDTH-1:0]   stage_out_s;
  logic [SHAMT_W-1:0] req_shamt_s;
  logic               unused_b_s;

  assign req_shamt_s = bus.req_b[SHAMT_W-1:0];
  assign unused_b_s  = ^bus.req_b[WIDTH-1:SHAMT_W];

  shift_stage #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_stage (
    .acc    (acc_r),
    .op     (op_r),
    .step   (step_r),
    .enable (shamt_r[step_r]),
    .result (stage_out_s)
  );

  // Sequencer FSM, step counter and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      step_r       <= {STEP_W{1'b0}};
      acc_r        <= {WIDTH{1'b0}};
      shamt_r      <= {SHAMT_W{1'b0}};
      op_r         <= OP_SLL;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            acc_r   <= bus.req_a;
            shamt_r <= req_shamt_s;
            op_r    <= op_e'(bus.req_op);
            step_r  <= {STEP_W{1'b0}};
            // A zero shift needs no stages; publish the operand directly
            if (req_shamt_s == {SHAMT_W{1'b0}}) begin
              state_r      <= DONE;
              rsp_valid_r  <= 1'b1;
              rsp_result_r <= bus.req_a;
            end else begin
              state_r <= SHIFT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          acc_r <= stage_out_s;
          if (step_r == LAST_STEP) begin
            state_r      <= DONE;
            step_r       <= {STEP_W{1'b0}};
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= stage_out_s;
          end else begin
            step_r <= step_r + STEP_ONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.busy       = (state_r != IDLE);
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: transaction-level reference model plus
// directed vectors with hand-computed results and latencies.
module tb_shift_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  shift_seq_if #(.WIDTH(WIDTH)) bus ();

  shift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned n;
    n = b % WIDTH;
    case (op)
      2'b00:   return a << n;
      2'b01:   return a >> n;
      2'b11:   return $signed(a) >>> n;
      default: return a;
    endcase
  endfunction

  // Reference model: 0 idle, 1 computing, 2 result offered
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [31:0] m_pend  = 32'h0;
  logic [31:0] m_res   = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_pend  <= 32'h0;
      m_res   <= 32'h0;
    end else if (m_phase == 0) begin
      if (bus.req_valid) begin
        if (bus.req_b % WIDTH == 0) begin
          m_phase <= 2;
          m_res   <= bus.req_a;
        end else begin
          m_phase <= 1;
          m_cnt   <= SHAMT_W;
          m_pend  <= ref_shift(bus.req_op, bus.req_a, bus.req_b);
        end
      end
    end else if (m_phase == 1) begin
      if (m_cnt == 1) begin
        m_phase <= 2;
        m_res   <= m_pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (bus.rsp_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(bus.req_ready), 32'(m_phase == 0));
    check("busy",      32'(bus.busy),      32'(m_phase != 0));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_phase == 2));
    check("rsp_result", bus.rsp_result, m_res);
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_op    = 2'($urandom);
  endtask

  task automatic collect(input logic [31:0] exp, input int lat, input string name);
    int cyc;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " result"}, bus.rsp_result, exp);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string name);
    issue(op, a, b);
    collect(exp, lat, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h0;
    bus.rsp_ready = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    check("reset req_ready",  32'(bus.req_ready), 32'h1);
    check("reset busy",       32'(bus.busy),      32'h0);
    check("reset rsp_valid",  32'(bus.rsp_valid), 32'h0);
    check("reset rsp_result", bus.rsp_result,     32'h0);

    run(2'b00, 32'h0000_0002, 32'd1,  32'h0000_0004, 5, "sll_2_1");
    run(2'b11, 32'hFFFF_FF85, 32'd2,  32'hFFFF_FFE1, 5, "sra_m123_2");
    run(2'b01, 32'hFFFF_FF85, 32'd3,  32'h1FFF_FFF0, 5, "srl_m123_3");
    run(2'b00, 32'h0000_FD40, 32'd3,  32'h0007_EA00, 5, "sll_fd40_3");
    run(2'b00, 32'h0000_FD40, 32'd35, 32'h0007_EA00, 5, "sll_fd40_35");
    run(2'b00, 32'h0000_FD40, 32'd0,  32'h0000_FD40, 0, "sll_fd40_0");
    run(2'b11, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 5, "sra_min_31");
    run(2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 5, "srl_min_31");
    run(2'b10, 32'h1234_5678, 32'd7,  32'h1234_5678, 5, "rsv_7");

    // Backpressure: result must hold while new requests knock at the door
    issue(2'b01, 32'hF000_0000, 32'd4);
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus.req_a = $urandom;
      bus.req_b = 32'(i + 1);
      @(posedge clk); #1;
      check("bp result",    bus.rsp_result,     32'h0F00_0000);
      check("bp req_ready", 32'(bus.req_ready), 32'h0);
      check("bp rsp_valid", 32'(bus.rsp_valid), 32'h1);
    end
    bus.req_a     = 32'h0000_0003;
    bus.req_b     = 32'd2;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp release req_ready", 32'(bus.req_ready), 32'h1);
    check("bp release rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp next accepted", 32'(bus.busy), 32'h1);
    collect(32'h0000_000C, 5, "bp_next_sll_3_2");

    // Reset in the middle of a shift abandons the operation
    issue(2'b00, 32'h0000_0001, 32'd31);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy",       32'(bus.busy),      32'h0);
    check("midrst rsp_valid",  32'(bus.rsp_valid), 32'h0);
    check("midrst rsp_result", bus.rsp_result,     32'h0);
    #20 rst_n = 1'b1;
    #1;
    check("postrst req_ready", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("postrst no rsp_valid", 32'(bus.rsp_valid), 32'h0);
    end
    run(2'b00, 32'h0000_0001, 32'd31, 32'h8000_0000, 5, "sll_1_31");

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift sequencer. It computes SLL, SRL and SRA on a WIDTH-bit operand by applying one conditional power-of-two shift stage per cycle, LSB of the shift amount first.
- It is a small-area alternative to the full single-cycle barrel Shift unit, intended for the area-reduced core variant.
- Sits behind the execute-stage issue logic. It takes requests through a valid/ready pair and returns results through a second valid/ready pair.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, number of shift-amount bits used; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved.
- req_a  input  WIDTH  operand to shift.
- req_b  input  WIDTH  shift amount; only bits [SHAMT_W-1:0] are used.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_result  output  WIDTH  shifted value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, step=0. rsp_valid=0, rsp_result=0, busy=0. Internal operand, shamt and op registers cleared. req_ready is high from the first cycle after rst_n deasserts.
- States: IDLE, SHIFT, DONE.
- req_ready = (state==IDLE), combinational from state only. busy = (state!=IDLE).
- Accept: on a rising edge with req_valid && req_ready:
  - latch acc=req_a, shamt=req_b[SHAMT_W-1:0], op=req_op; step=0.
  - If shamt==0: go to DONE. Otherwise go to SHIFT.
- SHIFT, each cycle:
  - If shamt[step]==1, shift acc by 2**step: SLL zero-fills from the LSB; SRL zero-fills from the MSB; SRA replicates acc[WIDTH-1] (sign at accept time is preserved, since shifting does not change the sign bit).
  - Reserved op 10: acc is left unchanged.
  - step increments each cycle. When step==SHAMT_W-1, go to DONE after that cycle's update.
  - SHIFT therefore lasts exactly SHAMT_W cycles whatever the shamt bit pattern.
- Latency, with accept edge = E0:
  - shamt!=0: rsp_valid rises after edge E0+SHAMT_W.
  - shamt==0: rsp_valid rises after edge E0+1 is not used; it is high in the cycle immediately after E0.
- DONE:
  - rsp_valid=1; rsp_result = acc, held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: go to IDLE and drop rsp_valid.
  - No new request is accepted in the same cycle (req_ready is low in DONE), so minimum throughput is one request per SHAMT_W+2 cycles.
- rsp_result holds the last delivered value in IDLE and SHIFT; it does not return to 0 until reset.
- Request inputs are ignored while not in IDLE. They may change freely and do not disturb the operation in flight.
- Width rules:
  - Upper bits of req_b are ignored, e.g. b=33 shifts by 1.
  - SRA of a negative operand by WIDTH-1 gives all ones.
  - SLL/SRL by WIDTH-1 leaves a single surviving bit.
- rst_n asserted mid-SHIFT or mid-DONE: the operation is abandoned. No rsp_valid pulse appears after reset release.

Decomposition:
- Package shift_pkg:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11, OP_RSV=2'b10;
  - state encoding IDLE/SHIFT/DONE.
- One sub-module, shift_stage. It is combinational: inputs acc, op, step, enable; output is acc conditionally shifted by 2**step.
- The FSM, step counter and handshake stay in shift_seq.

Test Plan:
- SLL a=2, b=1 -> rsp_result=0x00000004; rsp_valid rises exactly 5 cycles after the accept edge; busy high throughout.
- SRA a=-123 (0xFFFFFF85), b=2 -> 0xFFFFFFE1. SRL same a, b=3 -> 0x1FFFFFF0.
- SLL a=64832 (0x0000FD40), b=3 -> 0x0007EA00. b=35 -> also shifts by 3, same result. b=0 -> 0x0000FD40, rsp_valid in the cycle after accept.
- Backpressure: hold rsp_ready=0 for 4 cycles in DONE with req_valid=1 and changing req_a -> rsp_result stable, req_ready=0, no second accept. rsp_ready=1 -> IDLE, then the next request is accepted.
- SRA a=0x80000000, b=31 -> 0xFFFFFFFF. SRL a=0x80000000, b=31 -> 0x00000001. Reserved op 10 with a=0x12345678, b=7 -> 0x12345678.
- Assert rst_n=0 during SHIFT step 2 -> busy, rsp_valid, rsp_result become 0 immediately. After release, req_ready=1 and no spurious rsp_valid appears.
